bcd5_to_bin16: RTL and testbench



---
 rtl/bcd5_to_bin16_if.sv | 24 ++
 rtl/bcd5_to_bin16.sv | 125 ++++++++++++
 tb/tb_bcd5_to_bin16.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd5_to_bin16_if.sv
// Handshake/data bundle for the BCD-to-binary decoder.
// master: data-entry side issuing start/bcd_in; slave: the decoder.
interface bcd5_to_bin16_if #(
  parameter int DIGITS = 5,
  parameter int WIDTH  = 16
);
  logic                  start;
  logic [DIGITS*4-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      bin_out;
  logic                  ovf;
  logic                  bad_digit;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, ovf, bad_digit
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, ovf, bad_digit
  );
endinterface

// File: rtl/bcd5_to_bin16.sv
// Sequential packed-BCD to binary decoder (reverse double-dabble).
// One right shift of {bcd,bin} per clock, then every BCD digit >= 8 is
// reduced by 3. WIDTH iterations produce the binary result; whatever is
// left in the BCD section is the overflow quotient.
// Optional build macro BCD2BIN_SAT_EN: saturate bin_out to all ones on ovf.
module bcd5_to_bin16 #(
  parameter int DIGITS = 5,
  parameter int WIDTH  = 16
) (
  input  logic           clk,
  input  logic           RESET,
  bcd5_to_bin16_if.slave bus
);

  localparam int BW  = DIGITS * 4;
  localparam int TW  = BW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [BW-1:0]     bcd_sr;
  logic [WIDTH-1:0]  bin_sr;
  logic [CW-1:0]     cnt;

  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  bin_q;
  logic              ovf_q;
  logic              bad_q;

  logic [TW-1:0]     shifted;
  logic [BW-1:0]     nxt_bcd;
  logic [WIDTH-1:0]  nxt_bin;
  logic              in_bad;

  // One reverse double-dabble step: shift right, then correct each digit.
  always_comb begin
    shifted = {bcd_sr, bin_sr} >> 1;
    nxt_bin = shifted[WIDTH-1:0];
    nxt_bcd = shifted[TW-1:WIDTH];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (nxt_bcd[i*4 +: 4] >= 4'd8) begin
        nxt_bcd[i*4 +: 4] = nxt_bcd[i*4 +: 4] - 4'd3;
      end
    end
  end

  // Flags any input nibble outside 0..9.
  always_comb begin
    in_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[i*4 +: 4] > 4'd9) begin
        in_bad = 1'b1;
      end
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      bcd_sr <= '0;
      bin_sr <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bin_q  <= '0;
      ovf_q  <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            bcd_sr <= bus.bcd_in;
            bin_sr <= '0;
            cnt    <= '0;
            if (in_bad) begin
              state  <= DONE;
              done_q <= 1'b1;
              bin_q  <= '0;
              ovf_q  <= 1'b0;
              bad_q  <= 1'b1;
            end else begin
              state  <= CONV;
              busy_q <= 1'b1;
            end
          end
        end
        CONV: begin
          bcd_sr <= nxt_bcd;
          bin_sr <= nxt_bin;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            ovf_q  <= |nxt_bcd;
            bad_q  <= 1'b0;
`ifdef BCD2BIN_SAT_EN
            bin_q  <= (|nxt_bcd) ? '1 : nxt_bin;
`else
            bin_q  <= nxt_bin;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bin_out   = bin_q;
  assign bus.ovf       = ovf_q;
  assign bus.bad_digit = bad_q;

endmodule

// File: tb/tb_bcd5_to_bin16.sv
// Scoreboard bench for bcd5_to_bin16: stimulus pushes expected results
// (value, flags, cycle of done) and a negedge monitor pops on every done.
// Build with +define+BCD2BIN_SAT_EN to exercise the saturating variant.
module tb_bcd5_to_bin16;

  logic clk = 1'b0;
  logic RESET;
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] bin;
    logic        ovf;
    logic        bad;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

`ifdef BCD2BIN_SAT_EN
  localparam logic [15:0] EXP_99999 = 16'hFFFF;
  localparam logic [15:0] EXP_65536 = 16'hFFFF;
`else
  localparam logic [15:0] EXP_99999 = 16'h869F;
  localparam logic [15:0] EXP_65536 = 16'h0000;
`endif

  bcd5_to_bin16_if #(.DIGITS(5), .WIDTH(16)) bus ();

  bcd5_to_bin16 #(.DIGITS(5), .WIDTH(16)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time done against the accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!RESET && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with bin_out=%0h expected no done", bus.bin_out);
      end else begin
        e = sb.pop_front();
        chk("bin_out",        bus.bin_out,   e.bin);
        chk("ovf",            bus.ovf,       e.ovf);
        chk("bad_digit",      bus.bad_digit, e.bad);
        chk("done_latency",   cyc,           e.due);
        chk("busy_with_done", bus.busy,      1'b0);
      end
    end
  end

  // Called at a negedge: drives start for one edge; optionally records the
  // expected result. Valid input: done registered at the 16th edge after
  // the accepting edge; bad input: done registered at the accepting edge.
  task automatic issue(input logic [19:0] b, input logic [15:0] eb,
                       input logic eo, input logic ed, input bit push);
    exp_t e;
    bus.start  = 1'b1;
    bus.bcd_in = b;
    @(posedge clk);
    #1;
    if (push) begin
      e.bin = eb;
      e.ovf = eo;
      e.bad = ed;
      e.due = cyc + (ed ? 0 : 16);
      sb.push_back(e);
    end
    bus.start  = 1'b0;
    bus.bcd_in = 20'h99999;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    chk("wait_done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bcnt;
    RESET      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy",    bus.busy,      1'b0);
    chk("reset_done",    bus.done,      1'b0);
    chk("reset_bin_out", bus.bin_out,   16'h0);
    chk("reset_ovf",     bus.ovf,       1'b0);
    chk("reset_bad",     bus.bad_digit, 1'b0);
    RESET = 1'b0;
    @(negedge clk);

    // Basic conversion plus busy window of exactly 16 cycles.
    issue(20'h12345, 16'h3039, 1'b0, 1'b0, 1'b1);
    bcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
    end
    chk("busy_cycles", bcnt, 16);
    wait_idle();

    issue(20'h65535, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(20'h00000, 16'h0000, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(20'h99999, EXP_99999, 1'b1, 1'b0, 1'b1);
    wait_idle();
    issue(20'h65536, EXP_65536, 1'b1, 1'b0, 1'b1);
    wait_idle();
    issue(20'h09999, 16'h270F, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Invalid digits in middle, top and bottom positions.
    issue(20'h1A000, 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_idle();
    issue(20'hA0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_idle();
    issue(20'h0000F, 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Start pulses during conversion are ignored.
    issue(20'h54321, 16'hD431, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 20'h11111;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (4) @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 20'h22222;
    @(negedge clk);
    bus.start  = 1'b0;

    // Back-to-back: start held in the DONE cycle.
    wait_done();
    issue(20'h00007, 16'h0007, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(20'h00042, 16'h002A, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_busy", bus.busy, 1'b1);
    wait_idle();

    // Asynchronous reset mid-conversion aborts with no done.
    issue(20'h12345, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    RESET = 1'b1;
    #1;
    chk("abort_busy",    bus.busy,    1'b0);
    chk("abort_done",    bus.done,    1'b0);
    chk("abort_bin_out", bus.bin_out, 16'h0);
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_busy", bus.busy, 1'b0);
    issue(20'h09999, 16'h270F, 1'b0, 1'b0, 1'b1);
    wait_idle();

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
